// File: rtl/rf_wb_ctrl.sv
// rtl/rf_wb_ctrl.sv - register-file writeback arbiter with outstanding-load scoreboard
module rf_wb_ctrl #(
   parameter int MAX_PEND     = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_wb_valid,
   input  logic [4:0]  alu_wb_rd,
   input  logic [31:0] alu_wb_data,
   input  logic        lsu_wb_valid,
   input  logic [4:0]  lsu_wb_rd,
   input  logic [31:0] lsu_wb_data,
   output logic        lsu_wb_ready,
   input  logic        ld_issue,
   input  logic [4:0]  ld_issue_rd,
   output logic        ld_issue_ready,
   input  logic [4:0]  dec_rs1,
   input  logic        dec_rs1_en,
   input  logic [4:0]  dec_rs2,
   input  logic        dec_rs2_en,
   input  logic [4:0]  dec_rd,
   input  logic        dec_rd_en,
   output logic        hazard_stall,
   output logic        alu_hold,
   output logic        rf_rd_en,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_rd_data,
   output logic [3:0]  pend_cnt,
   output logic        err
);

   localparam logic [3:0] MAX_PEND_C  = 4'(MAX_PEND);
   localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

   // NORM: ALU owns the write port whenever it is valid.
   // HOLD: one cycle in which the starved LSU is pushed through.
   typedef enum logic {
      ST_NORM = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic [31:0] busy_q, busy_d;
   logic [3:0]  pend_cnt_q, pend_cnt_d;
   logic        alu_hold_q, alu_hold_d;
   logic        rf_rd_en_q, rf_rd_en_d;
   logic [4:0]  rf_rd_q, rf_rd_d;
   logic [31:0] rf_rd_data_q, rf_rd_data_d;
   logic        err_q, err_d;

   logic        alu_win;
   logic        lsu_acc;
   logic        issue_acc;

   // Arbitration FSM: write-port ownership, LSU ready and starvation tracking
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      lsu_wb_ready = 1'b0;
      alu_win      = 1'b0;
      if (!reset) begin
         if (state_q == ST_NORM) begin
            lsu_wb_ready = !alu_wb_valid;
            alu_win      = alu_wb_valid;
            if (lsu_wb_valid && alu_wb_valid) begin
               // LSU blocked this cycle; the LIMIT-th blocked cycle forces a HOLD
               starve_cnt_d = starve_cnt_q + 4'd1;
               if (starve_cnt_q == STARVE_LAST) begin
                  state_d = ST_HOLD;
               end
            end else begin
               starve_cnt_d = 4'd0;
            end
         end else begin
            // Ready is forced high, so the LSU either goes through or has gone
            // away; either way HOLD lasts exactly one cycle.
            lsu_wb_ready = 1'b1;
            state_d      = ST_NORM;
            starve_cnt_d = 4'd0;
         end
      end
   end

   // Load issue is accepted while there is room in the pending count
   always_comb begin
      ld_issue_ready = !reset && (pend_cnt_q < MAX_PEND_C);
   end

   // Handshake qualifiers shared by the scoreboard, writeback and error logic
   always_comb begin
      lsu_acc   = lsu_wb_valid && lsu_wb_ready;
      issue_acc = ld_issue && ld_issue_ready;
   end

   // Scoreboard: set on issue, clear on LSU writeback; set wins on equal rd
   always_comb begin
      busy_d = busy_q;
      if (lsu_acc) begin
         busy_d[lsu_wb_rd] = 1'b0;
      end
      if (issue_acc && (ld_issue_rd != 5'd0)) begin
         busy_d[ld_issue_rd] = 1'b1;
      end
   end

   // Outstanding-load count, saturating at both ends
   always_comb begin
      pend_cnt_d = pend_cnt_q;
      if (issue_acc && !lsu_acc) begin
         if (pend_cnt_q != MAX_PEND_C) begin
            pend_cnt_d = pend_cnt_q + 4'd1;
         end
      end else if (lsu_acc && !issue_acc) begin
         if (pend_cnt_q != 4'd0) begin
            pend_cnt_d = pend_cnt_q - 4'd1;
         end
      end
   end

   // Register-file write port: the winner of this cycle, x0 suppressed
   always_comb begin
      rf_rd_en_d   = 1'b0;
      rf_rd_d      = rf_rd_q;
      rf_rd_data_d = rf_rd_data_q;
      if (alu_win) begin
         rf_rd_en_d   = (alu_wb_rd != 5'd0);
         rf_rd_d      = alu_wb_rd;
         rf_rd_data_d = alu_wb_data;
      end else if (lsu_acc) begin
         rf_rd_en_d   = (lsu_wb_rd != 5'd0);
         rf_rd_d      = lsu_wb_rd;
         rf_rd_data_d = lsu_wb_data;
      end
   end

   // Sticky protocol-error detection
   always_comb begin
      err_d = err_q;
      if (lsu_acc && (lsu_wb_rd != 5'd0) && !busy_q[lsu_wb_rd]) begin
         err_d = 1'b1;
      end
      if (lsu_acc && (pend_cnt_q == 4'd0)) begin
         err_d = 1'b1;
      end
      if (ld_issue && !ld_issue_ready) begin
         err_d = 1'b1;
      end
      if ((state_q == ST_HOLD) && alu_wb_valid) begin
         err_d = 1'b1;
      end
   end

   // alu_hold mirrors the state being entered, so it is high during HOLD
   always_comb begin
      alu_hold_d = (state_d == ST_HOLD);
   end

   // Decode hazard: any enabled, non-x0 operand with a load still in flight
   always_comb begin
      hazard_stall = (dec_rs1_en && (dec_rs1 != 5'd0) && busy_q[dec_rs1]) ||
                     (dec_rs2_en && (dec_rs2 != 5'd0) && busy_q[dec_rs2]) ||
                     (dec_rd_en  && (dec_rd  != 5'd0) && busy_q[dec_rd]);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_NORM;
         starve_cnt_q <= 4'd0;
         alu_hold_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         alu_hold_q   <= alu_hold_d;
      end
   end

   // Scoreboard, counters, write port and error registers
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q       <= 32'd0;
         pend_cnt_q   <= 4'd0;
         rf_rd_en_q   <= 1'b0;
         rf_rd_q      <= 5'd0;
         rf_rd_data_q <= 32'd0;
         err_q        <= 1'b0;
      end else begin
         busy_q       <= busy_d;
         pend_cnt_q   <= pend_cnt_d;
         rf_rd_en_q   <= rf_rd_en_d;
         rf_rd_q      <= rf_rd_d;
         rf_rd_data_q <= rf_rd_data_d;
         err_q        <= err_d;
      end
   end

   assign alu_hold   = alu_hold_q;
   assign rf_rd_en   = rf_rd_en_q;
   assign rf_rd      = rf_rd_q;
   assign rf_rd_data = rf_rd_data_q;
   assign pend_cnt   = pend_cnt_q;
   assign err        = err_q;

endmodule
